uart_tx_generic: RTL and testbench

UART_TX_GENERIC -- requirements
Module: uart_tx_generic

---
 rtl/uart_tx_generic.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_generic.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_generic.sv
// rtl/uart_tx_generic.sv - FIFO-buffered UART transmitter, LSB first, registered serial line.
// Define UART_TX_GENERIC_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx_generic #(
  parameter int CLK_HZ     = 20000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        i_clk_mhz,
  input  logic                        i_rstn_mhz,
  input  logic [DATA_BITS-1:0]        i_tx_data,
  input  logic                        i_tx_valid,
  output logic                        o_tx_ready,
  output logic                        eo_uart_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV < 1) begin : g_bad_params
    $error("uart_tx_generic: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_GENERIC_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DIV_W-1:0]       baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic                   push, pop, bit_end;
`ifdef UART_TX_GENERIC_PARITY_EN
  logic                   par_q, par_d;
`endif

  always_comb begin
    push      = i_tx_valid & ready_q;
    pop       = 1'b0;
    bit_end   = (baud_q == BAUD_LAST);
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    baud_d    = bit_end ? '0 : baud_q + DIV_W'(1);
`ifdef UART_TX_GENERIC_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
`ifdef UART_TX_GENERIC_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_GENERIC_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            // Chain straight into the next frame so queued bytes leave with no idle gap.
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      baud_d  = '0;
`ifdef UART_TX_GENERIC_PARITY_EN
      par_d   = (^mem_q[rd_ptr_q]) ^ (PARITY_ODD != 0);
`endif
    end

    // Line value follows the current state, so every bit is delayed uniformly by one clock.
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_GENERIC_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy_d   = (state_d != S_IDLE);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    ready_d  = (count_d != FULL);
  end

  always_ff @(posedge i_clk_mhz) begin
    if (!i_rstn_mhz) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_TX_GENERIC_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_TX_GENERIC_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_ff @(posedge i_clk_mhz) begin
    if (push) mem_q[wr_ptr_q] <= i_tx_data;
  end

  assign o_tx_ready   = ready_q;
  assign eo_uart_tx   = tx_q;
  assign o_busy       = busy_q;
  assign o_fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_generic.sv
// tb/tb_uart_tx_generic.sv - randomized scoreboard bench for uart_tx_generic.
// Frame layout follows UART_TX_GENERIC_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_tx_generic;
`ifdef UART_TX_GENERIC_PARITY_EN
  localparam int DATA_BITS = 7, STOP_BITS = 2, PARITY_ODD = 1, PAR_BITS = 1;
  localparam logic [7:0] FIRST_BYTE = 8'h41;
`else
  localparam int DATA_BITS = 8, STOP_BITS = 1, PARITY_ODD = 0, PAR_BITS = 0;
  localparam logic [7:0] FIRST_BYTE = 8'hA5;
`endif
  localparam int CLK_HZ     = 20000000;
  localparam int BAUD       = 115200;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 174;
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

  logic                        clk = 1'b0;
  logic                        rstn;
  logic [DATA_BITS-1:0]        tx_data;
  logic                        tx_valid;
  logic                        tx_ready;
  logic                        uart_tx;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] drv_q[$];

  uart_tx_generic #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
    .PARITY_ODD(PARITY_ODD), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk_mhz(clk),
    .i_rstn_mhz(rstn),
    .i_tx_data(tx_data),
    .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready),
    .eo_uart_tx(uart_tx),
    .o_busy(busy),
    .o_fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit idx of a frame: start, data LSB first, optional parity, stop bits.
  function automatic logic expect_bit(input logic [7:0] data, input int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= DATA_BITS) return data[idx-1];
    if (PAR_BITS == 1 && idx == DATA_BITS + 1) begin
      for (int i = 0; i < DATA_BITS; i++) ones += int'(data[i]);
      return ((ones % 2) == 1) ^ (PARITY_ODD == 1);
    end
    return 1'b1;
  endfunction

  task automatic expect_frame(input string tag, input int exp_gap);
    logic [7:0] data;
    int gap, busy_low;
    bit seen;
    gap = 0; busy_low = 0; seen = 1'b0;
    data = exp_q.pop_front();
    for (int w = 0; w < 4 * BIT_CLKS; w++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      gap++;
    end
    check_eq({tag, " start"}, 32'(seen), 32'd1);
    if (!seen) return;
    check_eq({tag, " gap"}, gap, exp_gap);
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0 || c == BIT_CLKS - 1)
          check_eq($sformatf("%s bit%0d c%0d", tag, b, c), 32'(uart_tx), 32'(expect_bit(data, b)));
        if (!(b == FRAME_BITS - 1 && c == BIT_CLKS - 1) && busy !== 1'b1) busy_low++;
      end
    end
    check_eq({tag, " busy"}, busy_low, 0);
  endtask

  // Pushes drv_q on consecutive edges starting from an idle, empty transmitter.
  // The first byte is taken by the transmitter one edge after it lands, so occupancy
  // after push i is 1, then i, capped at the depth.
  task automatic drive_burst(input string tag);
    int n, exp_cnt;
    n = drv_q.size();
    for (int i = 0; i < n; i++) begin
      tx_data  = drv_q[i][DATA_BITS-1:0];
      tx_valid = 1'b1;
      @(negedge clk);
      exp_cnt = (i == 0) ? 1 : ((i < FIFO_DEPTH) ? i : FIFO_DEPTH);
      check_eq($sformatf("%s count%0d", tag, i), 32'(fifo_count), exp_cnt);
      check_eq($sformatf("%s ready%0d", tag, i), 32'(tx_ready), 32'(exp_cnt != FIFO_DEPTH));
    end
    tx_valid = 1'b0;
    drv_q.delete();
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq({tag, " quiet"}, bad, 0);
    check_eq({tag, " empty"}, 32'(fifo_count), 32'd0);
  endtask

  task automatic run_burst(input string tag);
    int n_acc;
    n_acc = 0;
    exp_q.delete();
    foreach (drv_q[i]) begin
      if (i <= FIFO_DEPTH) begin
        exp_q.push_back(drv_q[i]);
        n_acc++;
      end
    end
    fork
      drive_burst(tag);
      begin
        for (int i = 0; i < n_acc; i++)
          expect_frame($sformatf("%s f%0d", tag, i), (i == 0) ? 2 : 0);
      end
    join
    check_quiet(tag, 2 * BIT_CLKS);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    rstn = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check_eq("reset line", 32'(uart_tx), 32'd1);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset count", 32'(fifo_count), 32'd0);
    check_eq("reset ready", 32'(tx_ready), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("release ready", 32'(tx_ready), 32'd1);
    check_eq("release line", 32'(uart_tx), 32'd1);

    drv_q = '{FIRST_BYTE};
    run_burst("single");

    drv_q = '{8'h00, 8'hFF, 8'h55};
    run_burst("b2b");

    drv_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
    run_burst("full");

    drv_q = '{8'h00, 8'($urandom), 8'($urandom)};
    drive_burst("rst");
    w = 0;
    while (uart_tx !== 1'b0 && w < 4 * BIT_CLKS) begin
      @(negedge clk);
      w++;
    end
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    check_eq("rst pre line", 32'(uart_tx), 32'd0);
    check_eq("rst pre busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("rst line", 32'(uart_tx), 32'd1);
    check_eq("rst count", 32'(fifo_count), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst ready", 32'(tx_ready), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rst release ready", 32'(tx_ready), 32'd1);
    check_quiet("rst", 3 * BIT_CLKS);
    drv_q = '{8'h3C};
    run_burst("post");

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      n = $urandom_range(1, FIFO_DEPTH + 2);
      for (int i = 0; i < n; i++) drv_q.push_back(8'($urandom));
      run_burst($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
